// File: rtl/adc_capture_buffer_if.sv
// rtl/adc_capture_buffer_if.sv - sample stream and renderer read port bundle
// Purpose: groups the ADC sample stream and the renderer read port of
//          adc_capture_buffer.
// Signals:
//   sample_valid, sample_in : ADC side -> buffer
//   rd_en                   : renderer -> buffer
//   rd_data, rd_valid       : buffer -> renderer (registered)
// Modports: master = ADC/renderer side, slave = buffer.
interface adc_capture_buffer_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8
);
  logic             sample_valid;
  logic [IN_W-1:0]  sample_in;
  logic             rd_en;
  logic [OUT_W-1:0] rd_data;
  logic             rd_valid;

  modport master (output sample_valid, sample_in, rd_en,
                  input  rd_data, rd_valid);
  modport slave  (input  sample_valid, sample_in, rd_en,
                  output rd_data, rd_valid);
endinterface

// File: rtl/adc_capture_buffer.sv
// rtl/adc_capture_buffer.sv - triggered ADC capture buffer with scaled samples
// Purpose: scales raw ADC samples (shift, offset, saturate to OUT_W bits) and
//          captures one DEPTH-entry trace, free-running or level-triggered,
//          only once the previous trace has been fully read out.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   enable     : permits arming a new capture
//   mode       : 00 free-run, 01 rising, 10 falling, 11 single-shot rising
//   rearm      : leaves HOLD after a single-shot capture
//   trig_level : trigger threshold in scaled units
//   bus        : sample stream in, registered read port out
//   count      : entries held; empty / full flags
//   capturing  : waiting for trigger or filling
//   finished   : one-cycle pulse when the buffer becomes full
module adc_capture_buffer #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 7,
  parameter int OFFSET = 4,
  parameter int DEPTH  = 640,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 rearm,
  input  logic [OUT_W-1:0]     trig_level,
  adc_capture_buffer_if.slave  bus,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 capturing,
  output logic                 finished
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = IN_W - SHIFT;
  // Wide enough for the shifted sample and for the saturation limit.
  localparam int XW = SW + OUT_W + 1;
  localparam logic [XW-1:0] OFS_X = XW'(OFFSET);
  localparam logic [XW-1:0] MAX_X = XW'((1 << OUT_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_FILL,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           state, state_d;
  logic [1:0]       mode_q;
  logic [OUT_W-1:0] prev;
  logic             prev_valid;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OUT_W-1:0] mem [DEPTH];

  logic [XW-1:0]    s_x, v_x;
  logic [OUT_W-1:0] scaled;
  logic             rise_hit, fall_hit, trig_hit;
  logic             wr_fire, rd_fire, arm;
  logic [CW-1:0]    count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Offset subtraction floors at zero; anything above the output range clamps.
  always_comb begin
    s_x    = XW'(bus.sample_in >> SHIFT);
    v_x    = (s_x >= OFS_X) ? s_x - OFS_X : '0;
    scaled = (v_x > MAX_X) ? '1 : v_x[OUT_W-1:0];
  end

  always_comb begin
    rise_hit = prev_valid && (prev < trig_level) && (scaled >= trig_level);
    fall_hit = prev_valid && (prev > trig_level) && (scaled <= trig_level);
    trig_hit = (mode_q == 2'b10) ? fall_hit : rise_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    wr_fire = 1'b0;
    arm     = 1'b0;
    rd_fire = bus.rd_en && !empty;
    case (state)
      S_IDLE: begin
        if (enable && empty) begin
          arm     = 1'b1;
          state_d = (mode == 2'b00) ? S_FILL : S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (bus.sample_valid && trig_hit) begin
          wr_fire = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL:  wr_fire = bus.sample_valid;
      S_DRAIN: if (empty) state_d = (mode_q == 2'b11) ? S_HOLD : S_IDLE;
      S_HOLD:  if (rearm) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    count_d = count + CW'(wr_fire) - CW'(rd_fire);
    // A concurrent read keeps count below DEPTH, so the fill continues.
    if (wr_fire && count_d == CW'(DEPTH)) state_d = S_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q       <= 2'b00;
      prev         <= '0;
      prev_valid   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      capturing    <= 1'b0;
      finished     <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      count     <= count_d;
      empty     <= (count_d == '0);
      full      <= (count_d == CW'(DEPTH));
      capturing <= (state_d == S_WAIT_TRIG) || (state_d == S_FILL);
      finished  <= wr_fire && (count_d == CW'(DEPTH));
      bus.rd_valid <= rd_fire;
      if (arm) begin
        mode_q     <= mode;
        prev_valid <= 1'b0;
      end else if (state == S_WAIT_TRIG && bus.sample_valid) begin
        prev       <= scaled;
        prev_valid <= 1'b1;
      end
      if (wr_fire) wr_ptr <= ptr_next(wr_ptr);
      if (rd_fire) begin
        rd_ptr      <= ptr_next(rd_ptr);
        bus.rd_data <= mem[rd_ptr];
      end
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset && wr_fire) mem[wr_ptr] <= scaled;
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb/tb_adc_capture_buffer.sv - randomized and directed bench for adc_capture_buffer
module tb_adc_capture_buffer;
  localparam int IN_W   = 14;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 7;
  localparam int OFFSET = 4;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int CW5    = $clog2(4 + 1);

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_FILL = 2, PH_DRAIN = 3, PH_HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, enable, rearm;
  logic [1:0]       mode;
  logic [OUT_W-1:0] trig_level;
  logic [CW-1:0]    count;
  logic             empty, full, capturing, finished;

  logic             enable5;
  logic [CW5-1:0]   count5;
  logic             empty5, full5, capturing5, finished5;

  int errors = 0;
  int checks = 0;

  adc_capture_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  adc_capture_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus5 ();

  adc_capture_buffer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .OFFSET(OFFSET), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rearm(rearm),
    .trig_level(trig_level), .bus(bus), .count(count), .empty(empty),
    .full(full), .capturing(capturing), .finished(finished)
  );

  adc_capture_buffer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(5), .OFFSET(OFFSET), .DEPTH(4)
  ) dut5 (
    .clk(clk), .reset(reset), .enable(enable5), .mode(2'b00), .rearm(1'b0),
    .trig_level(8'd0), .bus(bus5), .count(count5), .empty(empty5),
    .full(full5), .capturing(capturing5), .finished(finished5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale(input int raw, input int sh);
    int s, v;
    s = raw >> sh;
    v = (s >= OFFSET) ? s - OFFSET : 0;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [IN_W-1:0] raw_of(input int v);
    return IN_W'(((v + OFFSET) << SHIFT) | int'($urandom_range(0, 127)));
  endfunction

  // Behavioural model: the trace is a queue, the phase a plain integer.
  int q[$];
  int ph, lmode, prev_m, m_old, m_v;
  bit pv_m, m_hit, m_take, model_live = 1'b0;
  bit exp_rd_valid, exp_finished;
  int exp_rd_data;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      ph = PH_IDLE; lmode = 0; prev_m = 0; pv_m = 0;
      exp_rd_valid = 0; exp_rd_data = 0; exp_finished = 0;
      model_live = 1;
    end else if (model_live) begin
      m_old = q.size();
      m_take = 0;
      exp_finished = 0;
      exp_rd_valid = 0;
      if (bus.rd_en && m_old > 0) begin
        exp_rd_data = q.pop_front();
        exp_rd_valid = 1;
      end
      case (ph)
        PH_IDLE: if (enable && m_old == 0) begin
          lmode = int'(mode); pv_m = 0;
          ph = (mode == 2'b00) ? PH_FILL : PH_WAIT;
        end
        PH_WAIT: if (!enable) ph = PH_IDLE;
                 else if (bus.sample_valid) begin
                   m_v = scale(int'(bus.sample_in), SHIFT);
                   if (lmode == 2) m_hit = pv_m && prev_m > int'(trig_level) && m_v <= int'(trig_level);
                   else            m_hit = pv_m && prev_m < int'(trig_level) && m_v >= int'(trig_level);
                   prev_m = m_v; pv_m = 1;
                   m_take = m_hit;
                 end
        PH_FILL:  m_take = bus.sample_valid;
        PH_DRAIN: if (m_old == 0) ph = (lmode == 3) ? PH_HOLD : PH_IDLE;
        PH_HOLD:  if (rearm) ph = PH_IDLE;
        default:  ph = PH_IDLE;
      endcase
      if (m_take) begin
        q.push_back(scale(int'(bus.sample_in), SHIFT));
        if (ph == PH_WAIT) ph = PH_FILL;
        if (q.size() == DEPTH) begin
          exp_finished = 1;
          ph = PH_DRAIN;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("count", 32'(count), q.size());
      chk("empty", 32'(empty), int'(q.size() == 0));
      chk("full", 32'(full), int'(q.size() == DEPTH));
      chk("capturing", 32'(capturing), int'(ph == PH_WAIT || ph == PH_FILL));
      chk("finished", 32'(finished), int'(exp_finished));
      chk("rd_valid", 32'(bus.rd_valid), int'(exp_rd_valid));
      chk("rd_data", 32'(bus.rd_data), exp_rd_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    bus.sample_valid = 1'b1;
    bus.sample_in = raw_of(v);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic fill_n(input int n);
    for (int i = 0; i < n; i++) feed($urandom_range(0, 123));
  endtask

  task automatic read_expect(input string name, input int lit);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk({name, "_valid"}, 32'(bus.rd_valid), 1);
    chk({name, "_data"}, 32'(bus.rd_data), lit);
    chk({name, "_model"}, exp_rd_data, lit);
  endtask

  task automatic drain();
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 2 && count != 0; i++) tick();
    bus.rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    tick();
  endtask

  logic [IN_W-1:0] fr_raw [8];
  int fr_exp [8];
  int fin;

  initial begin
    reset = 0; enable = 0; rearm = 0; mode = 2'b00; trig_level = '0;
    bus.sample_valid = 0; bus.sample_in = '0; bus.rd_en = 0;
    enable5 = 0; bus5.sample_valid = 0; bus5.sample_in = '0; bus5.rd_en = 0;
    repeat (3) tick();
    reset = 1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_capturing", 32'(capturing), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);

    // SHIFT=5 instance: 0x3FFF -> 511 - 4, clamped to 255.
    enable5 = 1; bus5.sample_valid = 1; bus5.sample_in = 14'h3FFF;
    repeat (5) tick();
    enable5 = 0; bus5.sample_valid = 0;
    chk("shift5_full", 32'(full5), 1);
    bus5.rd_en = 1; tick(); bus5.rd_en = 0;
    chk("shift5_valid", 32'(bus5.rd_valid), 1);
    chk("shift5_clamp", 32'(bus5.rd_data), 255);

    // Free-run: the sample on the arming edge is dropped.
    fr_raw[0] = 14'h0000; fr_raw[1] = 14'h0280; fr_raw[2] = 14'h3FFF;
    fr_exp[0] = 0; fr_exp[1] = 1; fr_exp[2] = 123;
    for (int i = 3; i < 8; i++) begin fr_raw[i] = raw_of(i); fr_exp[i] = i; end
    enable = 1; mode = 2'b00;
    bus.sample_valid = 1; bus.sample_in = raw_of(99);
    tick();
    chk("fr_capturing", 32'(capturing), 1);
    chk("fr_arm_drop", 32'(count), 0);
    fin = 0;
    for (int i = 0; i < 8; i++) begin
      bus.sample_in = fr_raw[i];
      tick();
      fin += int'(finished);
    end
    chk("fr_finished_at_full", 32'(finished), 1);
    for (int i = 0; i < 5; i++) begin
      bus.sample_in = IN_W'($urandom);
      tick();
      fin += int'(finished);
    end
    bus.sample_valid = 0;
    chk("fr_finished_once", fin, 1);
    chk("fr_count_held", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      read_expect("fr_read", fr_exp[i]);
      chk("fr_no_rearm", 32'(capturing), 0);
    end
    tick();
    chk("fr_drain_to_idle", 32'(capturing), 0);
    tick();
    chk("fr_rearm_after_empty", 32'(capturing), 1);
    fill_n(8);
    enable = 0;
    drain();

    // Rising trigger at 50 on 40,49,50,60; fill completes with enable low.
    mode = 2'b01; trig_level = 8'd50; enable = 1;
    tick();
    chk("rise_capturing", 32'(capturing), 1);
    feed(40); feed(49); feed(50); feed(60);
    chk("rise_count", 32'(count), 2);
    enable = 0;
    fill_n(6);
    chk("rise_full", 32'(full), 1);
    read_expect("rise_entry0", 50);
    read_expect("rise_entry1", 60);
    drain();

    // Falling trigger at 50 on 60,51,50.
    mode = 2'b10; enable = 1;
    tick();
    feed(60); feed(51); feed(50);
    chk("fall_count", 32'(count), 1);
    enable = 0;
    fill_n(7);
    read_expect("fall_entry0", 50);
    drain();

    // Single-shot: HOLD ignores samples and enable until rearm.
    mode = 2'b11; trig_level = 8'd10; enable = 1;
    tick();
    feed(5); feed(20);
    fill_n(7);
    chk("ss_full", 32'(full), 1);
    bus.rd_en = 1; bus.sample_valid = 1;
    for (int i = 0; i < DEPTH + 2 && count != 0; i++) begin
      bus.sample_in = IN_W'($urandom);
      tick();
    end
    bus.rd_en = 0;
    mode = 2'b00;
    repeat (6) begin
      bus.sample_in = IN_W'($urandom);
      tick();
    end
    bus.sample_valid = 0;
    chk("ss_hold_count", 32'(count), 0);
    chk("ss_hold_idle", 32'(capturing), 0);
    rearm = 1; tick(); rearm = 0;
    chk("ss_rearm_idle", 32'(capturing), 0);
    tick();
    chk("ss_new_capture", 32'(capturing), 1);

    // Concurrent read and write in FILL, pointers wrapping.
    fill_n(4);
    bus.rd_en = 1; bus.sample_valid = 1;
    for (int i = 0; i < 10; i++) begin
      bus.sample_in = raw_of($urandom_range(0, 123));
      tick();
    end
    bus.rd_en = 0; bus.sample_valid = 0;
    chk("conc_count_steady", 32'(count), 4);
    fill_n(4);
    chk("conc_full", 32'(full), 1);
    enable = 0;
    drain();
    bus.rd_en = 1; tick(); bus.rd_en = 0;
    chk("empty_read_valid", 32'(bus.rd_valid), 0);

    // Reset mid-fill at count 5, then a fresh capture from entry 0.
    enable = 1; mode = 2'b00;
    tick();
    fill_n(5);
    chk("mid_count5", 32'(count), 5);
    reset = 0; tick(); reset = 1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_capturing", 32'(capturing), 0);
    chk("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    tick();
    for (int i = 0; i < 8; i++) feed(11 + i);
    read_expect("after_rst_entry0", 11);
    enable = 0;
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) != 0);
      enable = ($urandom_range(0, 9) < 7);
      mode = 2'($urandom);
      rearm = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) trig_level = 8'($urandom_range(0, 120));
      bus.sample_valid = ($urandom_range(0, 9) < 7);
      bus.sample_in = $urandom_range(0, 1) ? raw_of($urandom_range(0, 123)) : IN_W'($urandom);
      bus.rd_en = ($urandom_range(0, 9) < 4);
      tick();
    end
    reset = 1; bus.rd_en = 0; bus.sample_valid = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
